// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Types, constants and helpers shared by the UART transmit path.
//
//   UART_DATA_W  - payload width of one serial character (8N1 framing)
//   tx_state_t   - serializer states, IDLE -> START -> DATA -> [PARITY] -> STOP
//   even_parity  - parity bit that makes the total number of ones even
//
//   The PARITY state is always part of the enum so that both builds share one
//   encoding. It is only reachable when UART_TX_PARITY_EN is defined.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity: the XOR of the data bits, so data plus parity bit always
  // holds an even number of ones.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   Serializer core: baud counter, shift register and framing FSM. It pulls
//   bytes through a valid/ready pop interface. When the stop bit ends and
//   another byte is waiting, that byte is taken at once, so frames sit back to
//   back on the line.
//
//   Optional build macro: UART_TX_PARITY_EN adds an even-parity bit after data
//   bit 7. Without the macro the frame is 8N1.
//
//   Ports
//     i_clk      system clock, rising edge
//     i_rst      synchronous, active-high reset
//     pop_valid  a byte is available at pop_data
//     pop_data   byte offered by the buffer (show-ahead head word)
//     pop_ready  the core takes pop_data at this edge (valid && ready = pop)
//     txd        registered serial line, idles high
//     active     a frame is in progress (state is not IDLE)
// ----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   pop_valid,
  input  logic [UART_DATA_W-1:0] pop_data,
  output logic                   pop_ready,
  output logic                   txd,
  output logic                   active
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);

  tx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  // The line value is derived from the current state and registered. The
  // line therefore lags the state register by one clock. Every bit still
  // lasts exactly CLKS_PER_BIT cycles, and o_txd has no glitches.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves one unassigned would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pop_ready = 1'b0;
    txd_d     = 1'b1;
    bit_end   = (cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    // The baud counter runs only inside a frame. It wraps at terminal count,
    // and that wrap marks the bit boundary.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        txd_d     = 1'b1;
        pop_ready = 1'b1;
        if (pop_valid) begin
          shift_d = pop_data;
          cnt_d   = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(pop_data);
`endif
        end
      end

      START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = par_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          // On the last stop cycle, a waiting byte goes straight into a new
          // start bit, so no idle gap appears between frames.
          pop_ready = 1'b1;
          if (pop_valid) begin
            shift_d = pop_data;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(pop_data);
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state elements use non-blocking assignments. All registers then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd    = txd_q;
  assign active = (state_q != IDLE);

endmodule

// File: rtl/uart_tx_wrap.sv
// ----------------------------------------------------------------------------
// uart_tx_wrap
//   UART transmitter with a buffered AXI-Stream byte input. Each byte accepted
//   on the slave port enters a show-ahead FIFO. The uart_tx core drains the
//   FIFO onto the serial line, LSB first.
//
//   Optional build macro: UART_TX_PARITY_EN (even parity, 11-bit frame).
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//     FIFO_DEPTH    FIFO entries (power of two, >= 2)
//
//   Ports
//     i_clk            system clock, rising edge
//     i_rst            synchronous, active-high reset
//     i_s_axis_tvalid  input byte valid
//     i_s_axis_tdata   input byte, sampled only at a handshake
//     o_s_axis_tready  FIFO can accept a byte (registered, low in reset)
//     o_txd            serial data line, idles high
//     o_busy           a frame is in flight or the FIFO holds data (registered)
// ----------------------------------------------------------------------------
module uart_tx_wrap
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_s_axis_tvalid,
  input  logic [UART_DATA_W-1:0] i_s_axis_tdata,
  output logic                   o_s_axis_tready,
  output logic                   o_txd,
  output logic                   o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [UART_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   tready_q;
  logic                   busy_q;

  logic                   push;
  logic                   pop;
  logic                   fifo_valid;
  logic                   core_ready;
  logic                   core_active;
  logic                   core_txd;

  assign fifo_valid = (count_q != '0);
  assign push       = i_s_axis_tvalid && tready_q;
  assign pop        = fifo_valid && core_ready;

  // A push together with a pop leaves the fill level unchanged. A push into a
  // full FIFO cannot happen because tready is low then. A pop from an empty
  // FIFO cannot happen because valid is low then.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are PTR_W bits wide, so they wrap modulo the power-of-two depth
  // without any extra logic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      // Ready is registered and taken from the next fill level. The FIFO
      // therefore never accepts a byte once it is full.
      tready_q <= (count_d != CNT_FULL);
      busy_q   <= core_active || fifo_valid;
    end
  end

  // NOTE: the storage array has no reset. After reset the pointers and the
  // count mark every entry as empty, so stale contents are never read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_s_axis_tdata;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .pop_valid (fifo_valid),
    .pop_data  (mem[rd_ptr_q]),
    .pop_ready (core_ready),
    .txd       (core_txd),
    .active    (core_active)
  );

  assign o_s_axis_tready = tready_q;
  assign o_txd           = core_txd;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_wrap.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_wrap
//   Self-checking bench for uart_tx_wrap with CLKS_PER_BIT=4, FIFO_DEPTH=16.
//   A line monitor decodes serial frames by sampling the middle of each bit.
//   Accepted bytes go into an expected-data queue. Line timing is checked
//   against the frame layout: start, 8 data bits LSB first, optional even
//   parity, stop.
// ----------------------------------------------------------------------------
module tb_uart_tx_wrap;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tready;
  logic       txd;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Line monitor state
  logic [7:0]  rx_q[$];
  int          starts_q[$];
  int          frame_err = 0;
  bit          in_frame  = 0;
  int          off       = 0;
  logic [10:0] bits;

  // Scoreboard and stimulus bookkeeping
  logic [7:0] exp_q[$];
  int         acc_times[$];
  int         n_acc;
  int         first_full;
  int         sent;
  int         lows;
  bit         acc;

  uart_tx_wrap #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_s_axis_tvalid (tvalid),
    .i_s_axis_tdata  (tdata),
    .o_s_axis_tready (tready),
    .o_txd           (txd),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level at bit slot pos of the frame for byte d.
  function automatic logic line_bit(input logic [7:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (pos == NBITS - 1) return 1'b1;
    return ^d;
  endfunction

  // Mid-bit sampling decoder. Offset 0 is the first low sample of a start bit.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (txd === 1'b0) begin
        in_frame = 1;
        off      = 0;
        bits     = '0;
        starts_q.push_back(cyc);
      end
    end else begin
      off++;
      if (off % CPB == CPB / 2) begin
        bits[off / CPB] = txd;
        if (off / CPB == NBITS - 1) begin
          if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) frame_err++;
`ifdef UART_TX_PARITY_EN
          if (bits[9] !== ^bits[8:1]) frame_err++;
`endif
          rx_q.push_back(bits[8:1]);
          in_frame = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) break;
      step();
    end
    check("idle_timeout", busy, 0);
    repeat (4) step();
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  // Cycle-exact check of one frame sent from idle: the byte is accepted at
  // edge N, the line falls at N+2, and busy drops when the stop bit ends.
  task automatic send_and_check(input logic [7:0] d);
    rx_q.delete();
    tvalid = 1'b1;
    tdata  = d;
    check("send_ready", tready, 1);
    step();                                    // edge N
    tvalid = 1'b0;
    check("n0_txd", txd, 1);
    check("n0_busy", busy, 0);
    step();                                    // edge N+1
    check("n1_txd", txd, 1);
    check("n1_busy", busy, 1);
    for (int k = 0; k < FRAME_CYC; k++) begin
      step();                                  // edge N+2+k
      check($sformatf("line_%02h_%0d", d, k), txd, line_bit(d, k / CPB));
    end
    check("busy_last", busy, 1);
    step();
    check("busy_end", busy, 0);
    check("txd_end", txd, 1);
    repeat (2) step();
    check("mon_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("mon_byte", rx_q[0], d);
  endtask

  initial begin
    rst    = 1'b1;
    tvalid = 1'b0;
    tdata  = '0;
    repeat (2) step();
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_tready", tready, 0);
    rst = 1'b0;
    step();
    check("post_rst_tready", tready, 1);
    check("post_rst_busy", busy, 0);

    // Single byte, exact timing
    send_and_check(8'hA5);
`ifdef UART_TX_PARITY_EN
    send_and_check(8'h07);
    send_and_check(8'h03);
`endif

    // Back-to-back: three bytes on consecutive cycles
    rx_q.delete(); starts_q.delete(); exp_q.delete();
    tvalid = 1'b1;
    foreach (exp_q[i]) ;
    exp_q = '{8'h00, 8'hFF, 8'h55};
    for (int i = 0; i < 3; i++) begin
      tdata = exp_q[i];
      check($sformatf("b2b_ready%0d", i), tready, 1);
      step();
    end
    tvalid = 1'b0;
    wait_idle(400);
    compare_queues("b2b");
    check("b2b_starts", starts_q.size(), 3);
    for (int i = 1; i < starts_q.size(); i++)
      check($sformatf("b2b_gap%0d", i), starts_q[i] - starts_q[i-1], FRAME_CYC);

    // Backpressure: tvalid held high continuously
    rx_q.delete(); starts_q.delete(); exp_q.delete(); acc_times.delete();
    n_acc      = 0;
    first_full = -1;
    tvalid     = 1'b1;
    tdata      = 8'($urandom);
    for (int c = 0; c < 400 && n_acc < 21; c++) begin
      acc = (tready === 1'b1);
      if (!acc && first_full < 0) first_full = n_acc;
      step();
      if (acc) begin
        exp_q.push_back(tdata);
        acc_times.push_back(cyc);
        n_acc++;
        tdata = 8'($urandom);
      end
    end
    tvalid = 1'b0;
    check("bp_accepts", n_acc, 21);
    check("bp_first_full", first_full, DEPTH + 1);
    for (int i = 18; i < acc_times.size(); i++)
      check($sformatf("bp_interval%0d", i), acc_times[i] - acc_times[i-1], FRAME_CYC);
    wait_idle(2000);
    compare_queues("bp");

    // Push and pop on the same edge with the FIFO at DEPTH-1, then random flow
    rx_q.delete(); starts_q.delete(); exp_q.delete();
    tvalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin      // edges N .. N+15
      tdata = 8'($urandom);
      exp_q.push_back(tdata);
      step();
    end
    tvalid = 1'b0;
    check("f1_ready_15", tready, 1);
    repeat (FRAME_CYC - DEPTH + 1) step();     // now just after edge N+40
    tvalid = 1'b1;
    tdata  = 8'($urandom);
    exp_q.push_back(tdata);
    check("f1_ready_pre", tready, 1);
    step();                                    // edge N+41: push and pop together
    check("f1_ready_same", tready, 1);
    tdata = 8'($urandom);
    exp_q.push_back(tdata);
    step();                                    // edge N+42: push only, FIFO full
    check("f1_ready_full", tready, 0);
    tvalid = 1'b0;
    sent = 0;
    for (int c = 0; c < 6000 && sent < 64; c++) begin
      tvalid = ($urandom_range(0, 3) != 0);
      tdata  = 8'($urandom);
      acc    = tvalid && (tready === 1'b1);
      step();
      if (acc) begin
        exp_q.push_back(tdata);
        sent++;
      end
    end
    tvalid = 1'b0;
    check("rnd_sent", sent, 64);
    wait_idle(3000);
    compare_queues("rnd");

    // Reset in the middle of data bit 3 of 0x3C, five more bytes queued
    rx_q.delete(); starts_q.delete(); exp_q.delete();
    tvalid = 1'b1;
    tdata  = 8'h3C;
    step();                                    // edge N
    for (int i = 0; i < 5; i++) begin
      tdata = 8'($urandom);
      step();                                  // edges N+1 .. N+5
    end
    tvalid = 1'b0;
    repeat (14) step();                        // edge N+19: data bit 3 on line
    check("mid_bit3", txd, line_bit(8'h3C, 4));
    check("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    check("mrst_txd", txd, 1);
    check("mrst_busy", busy, 0);
    check("mrst_tready", tready, 0);
    step();
    check("mrst_tready2", tready, 0);
    rst = 1'b0;
    step();
    check("mrst_release_ready", tready, 1);
    lows = 0;
    repeat (200) begin
      step();
      if (txd !== 1'b1) lows++;
    end
    check("mrst_line_quiet", lows, 0);
    check("mrst_busy_after", busy, 0);
    check("mrst_no_frames", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_wrap.md
Name: uart_tx_wrap

Overview:
- UART transmitter with buffered AXI-Stream byte input, 8N1 framing, LSB first.
- Accepts bytes on an AXIS slave port into an internal 16-deep show-ahead FIFO.
- A serializer core drains the FIFO onto the TX line back-to-back.
- Pairs with the receive path at the other end of the same serial link; instantiated per UART in the top level.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per serial bit; legal range >= 2.
- FIFO_DEPTH, 16, FIFO entries; power of 2, >= 2.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_s_axis_tvalid  in  1  input byte valid.
- i_s_axis_tdata  in  8  input byte.
- o_s_axis_tready  out  1  FIFO can accept a byte.
- o_txd  out  1  serial data line; idles high.
- o_busy  out  1  frame in flight or FIFO non-empty.

Behaviour:
- Reset: one clock, synchronous, active-high. While i_rst=1: o_txd=1, o_busy=0, o_s_axis_tready=0, FIFO pointers cleared, FSM in IDLE, counters=0.
- Reset mid-frame: o_txd returns to 1 on the next edge. The in-flight byte and all FIFO contents are discarded; the truncated frame is not resent.
- Handshake: a byte is written when tvalid && tready at a rising edge. o_s_axis_tready = ~full (registered count). tdata is only sampled at handshake.
- FIFO: show-ahead (head word visible combinationally), registered count 0..FIFO_DEPTH.
  - Simultaneous push and pop: both occur; count unchanged.
  - Pop when empty and push when full cannot occur by construction.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_txd=1. If FIFO non-empty: pop head into shift register, clear baud counter, go to START.
  - START: o_txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_txd=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7, go to STOP.
  - STOP: o_txd=1 for CLKS_PER_BIT cycles. On the last stop cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Bit boundary is at terminal count. No drift: every bit is exactly CLKS_PER_BIT cycles.
- Latency: byte accepted at edge N, o_txd falls at edge N+2 if the FSM is idle.
- Frame length: 10*CLKS_PER_BIT cycles (11 with parity). Consecutive frames are contiguous.
- o_txd is driven from a register (glitch-free).
- o_busy = (state != IDLE) || ~empty; registered.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted after data bit 7 via an extra PARITY state lasting CLKS_PER_BIT cycles. Frame is 11 bit-times.
- Undefined: no PARITY state and no parity logic; 8N1 framing.

Decomposition:
- Shared package uart_pkg:
  - typedef tx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - localparam UART_DATA_W = 8
  - even-parity function
- Sub-module uart_tx: serializer FSM, baud counter and shift register. Simple valid/ready pop interface toward the FIFO; mirrors the existing receive core.
- FIFO kept inline in uart_tx_wrap: small register array, show-ahead.

Test Plan:
- Single byte, CLKS_PER_BIT=4: send 0xA5 -> o_txd low at edge N+2, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; o_busy falls after 40 cycles.
- Back-to-back: push 0x00, 0xFF, 0x55 in consecutive cycles -> 120 contiguous line cycles, no idle between stop and next start; bytes decoded correctly by bench monitor.
- Backpressure: hold tvalid=1 continuously, CLKS_PER_BIT=4 -> tready drops after 17 accepted bytes (1 in serializer + 16 in FIFO). Re-asserts for exactly one accept per 40-cycle frame. All 17+ bytes emitted in order.
- Push and pop in the same cycle while full-1 -> count unchanged; no loss or duplication over 64 random bytes.
- Reset mid-DATA (bit 3 of 0x3C, 5 bytes queued) -> o_txd=1 next edge, o_busy=0, tready=0 during reset then 1. No further frames emitted.
- UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1 then stop; send 0x03 -> parity bit 0. Frame 44 cycles at CLKS_PER_BIT=4.
